// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the VGA raster timing generator.
package vga_pkg;

  // 800x600 @ 75 Hz
  localparam int unsigned SVGA75_H_SYNC    = 80;
  localparam int unsigned SVGA75_H_BACK    = 160;
  localparam int unsigned SVGA75_H_DISPLAY = 800;
  localparam int unsigned SVGA75_H_FRONT   = 16;
  localparam int unsigned SVGA75_V_SYNC    = 3;
  localparam int unsigned SVGA75_V_BACK    = 21;
  localparam int unsigned SVGA75_V_DISPLAY = 600;
  localparam int unsigned SVGA75_V_FRONT   = 1;

  // 640x480 @ 60 Hz
  localparam int unsigned VGA60_H_SYNC    = 96;
  localparam int unsigned VGA60_H_BACK    = 48;
  localparam int unsigned VGA60_H_DISPLAY = 640;
  localparam int unsigned VGA60_H_FRONT   = 16;
  localparam int unsigned VGA60_V_SYNC    = 2;
  localparam int unsigned VGA60_V_BACK    = 33;
  localparam int unsigned VGA60_V_DISPLAY = 480;
  localparam int unsigned VGA60_V_FRONT   = 10;

  localparam logic POL_ACTIVE_LOW  = 1'b0;
  localparam logic POL_ACTIVE_HIGH = 1'b1;

  localparam int unsigned MAX_LEAD = 7;

  function automatic int unsigned h_total(input int unsigned sync, input int unsigned back,
                                          input int unsigned disp, input int unsigned front);
    return sync + back + disp + front;
  endfunction

  function automatic int unsigned v_total(input int unsigned sync, input int unsigned back,
                                          input int unsigned disp, input int unsigned front);
    return sync + back + disp + front;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Synchronously resettable shift register; reset loads RST_VAL into every stage.
module vga_delay_line #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // One dummy stage keeps the array legal when DEPTH is 0; it is then bypassed.
  localparam int unsigned NStage = (DEPTH == 0) ? 1 : DEPTH;

  logic [WIDTH-1:0] stage_q [NStage];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NStage; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < NStage; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = (DEPTH == 0) ? d_i : stage_q[NStage-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, registered request-stage decode, and a
// LEAD-cycle delayed display stage so pixel fetches can be issued ahead of de.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC    = SVGA75_H_SYNC,
  parameter int unsigned H_BACK    = SVGA75_H_BACK,
  parameter int unsigned H_DISPLAY = SVGA75_H_DISPLAY,
  parameter int unsigned H_FRONT   = SVGA75_H_FRONT,
  parameter int unsigned V_SYNC    = SVGA75_V_SYNC,
  parameter int unsigned V_BACK    = SVGA75_V_BACK,
  parameter int unsigned V_DISPLAY = SVGA75_V_DISPLAY,
  parameter int unsigned V_FRONT   = SVGA75_V_FRONT,
  parameter logic        HS_POL    = POL_ACTIVE_LOW,
  parameter logic        VS_POL    = POL_ACTIVE_LOW,
  parameter int unsigned LEAD      = 2,
  parameter int unsigned CW        = 11
) (
  input  logic          vga_clk,
  input  logic          rst,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          line_start,
  output logic          frame_start,
  output logic          req,
  output logic [CW-1:0] req_col,
  output logic [CW-1:0] req_row
);

  localparam int unsigned HTotal    = h_total(H_SYNC, H_BACK, H_DISPLAY, H_FRONT);
  localparam int unsigned VTotal    = v_total(V_SYNC, V_BACK, V_DISPLAY, V_FRONT);
  localparam int unsigned HVisStart = H_SYNC + H_BACK;
  localparam int unsigned HVisEnd   = H_SYNC + H_BACK + H_DISPLAY;
  localparam int unsigned VVisStart = V_SYNC + V_BACK;
  localparam int unsigned VVisEnd   = V_SYNC + V_BACK + V_DISPLAY;
  localparam int unsigned BW        = 5 + 2 * CW;

  localparam logic [CW-1:0] HLast = CW'(HTotal - 1);
  localparam logic [CW-1:0] VLast = CW'(VTotal - 1);

  // Bundle layout: {hsync, vsync, de, line_start, frame_start, col, row}
  localparam logic [BW-1:0] IdleBundle = {~HS_POL, ~VS_POL, 3'b000, {(2 * CW){1'b0}}};

  if (LEAD > MAX_LEAD) begin : gen_bad_lead
    $error("vga_timing_gen: LEAD must be in 0..7");
  end
  if ((HTotal - 1) >= (2 ** CW) || (VTotal - 1) >= (2 ** CW)) begin : gen_bad_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic [BW-1:0] req_q, req_d;
  logic [BW-1:0] disp_bundle;

  logic h_vis, v_vis, vis;
  logic hs_d, vs_d, ls_d, fs_d;
  logic [CW-1:0] col_d, row_d;

  always_comb begin
    hcnt_d = (hcnt_q == HLast) ? '0 : hcnt_q + CW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == HLast) begin
      vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + CW'(1);
    end

    h_vis = (32'(hcnt_q) >= HVisStart) && (32'(hcnt_q) < HVisEnd);
    v_vis = (32'(vcnt_q) >= VVisStart) && (32'(vcnt_q) < VVisEnd);
    vis   = h_vis && v_vis;

    hs_d  = (32'(hcnt_q) < H_SYNC) ? HS_POL : ~HS_POL;
    vs_d  = (32'(vcnt_q) < V_SYNC) ? VS_POL : ~VS_POL;
    ls_d  = (hcnt_q == '0);
    fs_d  = (hcnt_q == '0) && (vcnt_q == '0);
    // Coordinates forced to 0 in blanking so no negative offsets leak out.
    col_d = vis ? CW'(32'(hcnt_q) - HVisStart) : '0;
    row_d = vis ? CW'(32'(vcnt_q) - VVisStart) : '0;

    req_d = {hs_d, vs_d, vis, ls_d, fs_d, col_d, row_d};
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      req_q  <= IdleBundle;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      req_q  <= req_d;
    end
  end

  assign req     = req_q[2*CW+2];
  assign req_col = req_q[2*CW-1:CW];
  assign req_row = req_q[CW-1:0];

  vga_delay_line #(
    .WIDTH  (BW),
    .DEPTH  (LEAD),
    .RST_VAL(IdleBundle)
  ) u_delay (
    .clk_i(vga_clk),
    .rst_i(rst),
    .d_i  (req_q),
    .q_o  (disp_bundle)
  );

  assign {hsync, vsync, de, line_start, frame_start, col, row} = disp_bundle;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small raster (H 2/3/8/1, V 1/1/4/1) with LEAD=2 active-low syncs,
// plus a LEAD=0 active-high twin, checked cycle by cycle against a raster model.
module tb_vga_timing_gen;

  localparam int HT    = 14;
  localparam int VT    = 7;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        hsync, vsync, de, line_start, frame_start, req;
  logic [10:0] col, row, req_col, req_row;
  logic        p_hsync, p_vsync, p_de, p_line_start, p_frame_start, p_req;
  logic [10:0] p_col, p_row, p_req_col, p_req_row;

  int checks = 0;
  int errors = 0;
  int de_cnt = 0;
  int ls_cnt = 0;
  int fs_cnt = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(3), .H_DISPLAY(8), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_DISPLAY(4), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(2), .CW(11)
  ) dut (
    .vga_clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .de(de), .col(col), .row(row),
    .line_start(line_start), .frame_start(frame_start), .req(req), .req_col(req_col),
    .req_row(req_row)
  );

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(3), .H_DISPLAY(8), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_DISPLAY(4), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .LEAD(0), .CW(11)
  ) dut_p (
    .vga_clk(clk), .rst(rst), .hsync(p_hsync), .vsync(p_vsync), .de(p_de), .col(p_col),
    .row(p_row), .line_start(p_line_start), .frame_start(p_frame_start), .req(p_req),
    .req_col(p_req_col), .req_row(p_req_row)
  );

  typedef struct packed {
    logic hs, vs, de, ls, fs;
    logic [10:0] col, row;
  } bnd_t;

  // Expected bundle for raster position n (cycles since counters left reset).
  function automatic bnd_t model(input int n, input logic hpol, input logic vpol);
    bnd_t b;
    int h, v;
    b    = '0;
    b.hs = ~hpol;
    b.vs = ~vpol;
    if (n < 0) return b;
    h = n % HT;
    v = (n / HT) % VT;
    if (h < 2) b.hs = hpol;
    if (v < 1) b.vs = vpol;
    b.ls = (h == 0);
    b.fs = (h == 0) && (v == 0);
    if (h >= 5 && h < 13 && v >= 2 && v < 6) begin
      b.de  = 1'b1;
      b.col = 11'(h - 5);
      b.row = 11'(v - 2);
    end
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s n=%0d: observed %0h expected %0h", tag, n, got, exp);
    end
  endtask

  task automatic check_cycle(input int n);
    bnd_t r, d, p;
    r = model(n, 1'b0, 1'b0);
    d = model(n - 2, 1'b0, 1'b0);
    p = model(n, 1'b1, 1'b1);
    chk("req", n, 32'(req), 32'(r.de));
    chk("req_col", n, 32'(req_col), 32'(r.col));
    chk("req_row", n, 32'(req_row), 32'(r.row));
    chk("hsync", n, 32'(hsync), 32'(d.hs));
    chk("vsync", n, 32'(vsync), 32'(d.vs));
    chk("de", n, 32'(de), 32'(d.de));
    chk("col", n, 32'(col), 32'(d.col));
    chk("row", n, 32'(row), 32'(d.row));
    chk("line_start", n, 32'(line_start), 32'(d.ls));
    chk("frame_start", n, 32'(frame_start), 32'(d.fs));
    chk("p_hsync", n, 32'(p_hsync), 32'(p.hs));
    chk("p_vsync", n, 32'(p_vsync), 32'(p.vs));
    chk("p_de", n, 32'(p_de), 32'(p.de));
    chk("p_req", n, 32'(p_req), 32'(p.de));
    chk("p_col", n, 32'(p_col), 32'(p.col));
    chk("p_row", n, 32'(p_row), 32'(p.row));
    chk("p_line_start", n, 32'(p_line_start), 32'(p.ls));
    chk("p_frame_start", n, 32'(p_frame_start), 32'(p.fs));
  endtask

  task automatic check_idle(input int n);
    chk("idle_hsync", n, 32'(hsync), 32'd1);
    chk("idle_vsync", n, 32'(vsync), 32'd1);
    chk("idle_de", n, 32'(de), 32'd0);
    chk("idle_req", n, 32'(req), 32'd0);
    chk("idle_pulses", n, {30'd0, line_start, frame_start}, 32'd0);
    chk("idle_coords", n, {col, row, req_col[9:0]}, 32'd0);
    chk("idle_p_hsync", n, 32'(p_hsync), 32'd0);
    chk("idle_p_vsync", n, 32'(p_vsync), 32'd0);
    chk("idle_p_misc", n, {28'd0, p_de, p_req, p_line_start, p_frame_start}, 32'd0);
  endtask

  initial begin
    // Power-up reset
    rst = 1'b1;
    tick();
    tick();
    check_idle(-1);

    // Three full frames from reset release
    rst = 1'b0;
    for (int n = 0; n < 3 * FRAME; n++) begin
      tick();
      check_cycle(n);
      if (de) de_cnt++;
      if (line_start) ls_cnt++;
      if (frame_start) fs_cnt++;
      if (n == 0) begin
        chk("pwr_p_frame_start", n, 32'(p_frame_start), 32'd1);
        chk("pwr_frame_start_delayed", n, 32'(frame_start), 32'd0);
      end
      if (n == 2) chk("lead_frame_start", n, {30'd0, frame_start, line_start}, 32'd3);
      if (n == 33) chk("first_req", n, {req, req_col, req_row}, {1'b1, 22'd0});
      if (n == 34) chk("no_de_yet", n, 32'(de), 32'd0);
      if (n == 35) chk("first_de", n, {de, col, row}, {1'b1, 22'd0});
      if (n == 42) chk("last_col", n, {de, col}, {1'b1, 11'd7});
      if (n == 43) chk("de_fall", n, 32'(de), 32'd0);
      if (n == 84) chk("last_pixel", n, {col, row}, {11'd7, 11'd3});
      if (n == 100) chk("wrap_pulses", n, {30'd0, frame_start, line_start}, 32'd3);
      if (n == 101) chk("wrap_one_cycle", n, {30'd0, frame_start, line_start}, 32'd0);
      if (n == 133) chk("row_back_to_0", n, {de, col, row}, {1'b1, 22'd0});
    end
    chk("de_count", 0, 32'(de_cnt), 32'd96);
    chk("line_start_count", 0, 32'(ls_cnt), 32'd21);
    chk("frame_start_count", 0, 32'(fs_cnt), 32'd3);

    // Run into a visible line of frame 4, then reset mid-line for 3 cycles
    for (int n = 3 * FRAME; n <= 3 * FRAME + 3 * HT + 9; n++) begin
      tick();
      check_cycle(n);
    end
    chk("mid_line_req", 0, {req, req_col}, {1'b1, 11'd4});
    chk("mid_line_de", 0, {de, col}, {1'b1, 11'd2});
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle(1000 + i);
    end

    // Restart must match the power-up sequence
    rst = 1'b0;
    for (int n = 0; n <= 40; n++) begin
      tick();
      check_cycle(n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, next generation of the fixed 800x600@75 Hz sync block. Produces hsync/vsync with per-axis programmable polarity, a display-enable, in-frame pixel coordinates, line/frame start pulses, and an early pixel-request stream that leads display by LEAD cycles so frame-buffer/sprite ROM reads can be issued ahead of the pixel. Sits between the pixel clock and the renderer/frame-buffer fetch logic.

## Interface
- H_SYNC, 80, hsync pulse width (pixels); H_BACK, 160; H_DISPLAY, 800; H_FRONT, 16
- V_SYNC, 3, vsync pulse width (lines); V_BACK, 21; V_DISPLAY, 600; V_FRONT, 1
- HS_POL, 0, hsync active level (0 = active-low); VS_POL, 0, vsync active level
- LEAD, 2, cycles req_* leads de/col/row (0..7)
- CW, 11, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1
- vga_clk  in  1  pixel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- de  out  1  display enable (visible pixel)
- col  out  CW  visible x, 0..H_DISPLAY-1; 0 when de low
- row  out  CW  visible y, 0..V_DISPLAY-1; 0 when de low
- line_start  out  1  one-cycle pulse, first cycle of each line (aligned with hsync edge)
- frame_start  out  1  one-cycle pulse, first cycle of each frame
- req  out  1  pixel request, asserted LEAD cycles before the matching de
- req_col  out  CW  x of requested pixel; 0 when req low
- req_row  out  CW  y of requested pixel; 0 when req low

## Operation
- H_TOTAL = H_SYNC+H_BACK+H_DISPLAY+H_FRONT (1056 default); V_TOTAL likewise (625).
- Line order: sync, back porch, display, front porch; same for lines within a frame.
- hcnt counts 0..H_TOTAL-1, wraps to 0; vcnt increments only when hcnt == H_TOTAL-1, wraps at V_TOTAL-1 to 0.
- Sync active when hcnt < H_SYNC (resp. vcnt < V_SYNC); driven pin = active ? HS_POL : ~HS_POL.
- Visible when H_SYNC+H_BACK <= hcnt < H_SYNC+H_BACK+H_DISPLAY and same for vcnt; coordinate = cnt - (SYNC+BACK), truncated to CW.
- Request stage: registered decode of hcnt/vcnt → req, req_col, req_row, plus internal hsync/vsync/de/pulses.
- Display stage: request-stage bundle (syncs, de, coords, pulses) delayed LEAD cycles; LEAD=0 makes display stage identical to request stage.
- line_start at hcnt==0; frame_start at hcnt==0 && vcnt==0.

## Timing
- Reset (rst high at edge): hcnt=vcnt=0; every output at inactive value: hsync=~HS_POL, vsync=~VS_POL, de/req/pulses 0, coords 0; delay line flushed to the same inactive bundle.
- Reset mid-frame: same result on the next edge, no partial pulses afterwards.
- First edge with rst low: request stage shows hcnt=0,vcnt=0 (sync active, line_start=frame_start=1); display stage shows it LEAD edges later.
- Request-stage latency from counter: 1 cycle; display-stage latency: 1+LEAD.
- hsync active exactly H_SYNC cycles per line; de high exactly H_DISPLAY consecutive cycles on each of V_DISPLAY lines per frame.
- Frame period H_TOTAL*V_TOTAL cycles (660000 default), no drift.
- col increments by 1 each de cycle; row constant across a line; both 0 in blanking (no negative wrap values).
- vsync transitions coincide with hsync line boundary (hcnt==0).

## Structure
- Package vga_pkg: timing constant sets (800x600@75, 640x480@60) as localparams, polarity constants, derived H_TOTAL/V_TOTAL helper functions.
- Sub-module vga_delay_line (WIDTH, DEPTH): reset-flushable shift register with configurable reset value; DEPTH=0 is a passthrough. Instantiated once with the packed display bundle.
- Elaboration checks: LEAD <= 7; CW wide enough for H_TOTAL-1, V_TOTAL-1.

## Test plan
- Defaults, LEAD=0, release reset → hsync low for 80 cycles from first edge, de rises at cycle 240 of line 24, col 0..799 then de low; frame_start every 660000 cycles.
- Small params H 2/3/8/1, V 1/1/4/1, LEAD=2 → H_TOTAL 14, V_TOTAL 7; req rises exactly 2 cycles before de; req_col/req_row equal col/row 2 cycles later for every pixel.
- HS_POL=1, VS_POL=1 → hsync high for H_SYNC cycles, low otherwise; vsync high for V_SYNC*H_TOTAL cycles per frame.
- Reset asserted mid-visible-line (col≈400) for 3 cycles → outputs inactive next edge, no pulses during reset, restart identical to power-up sequence.
- Boundary: hcnt/vcnt wrap at last pixel of last line → frame_start and line_start pulse together for one cycle, row returns to 0 on first visible line of the next frame.
- Count check over 3 frames: de high-cycle count = 3*H_DISPLAY*V_DISPLAY, line_start count = 3*V_TOTAL.
